// File: rtl/sr_32bit_seq.sv
// sr_32bit_seq: multicycle 32-bit SRL/SRA coprocessor, one power-of-two
// stage per clock. Ports: clock, reset_n, data_operandA, ctrl_shiftamt,
// ctrl_arith, ctrl_start in; data_result, data_resultRDY, busy out.
module sr_32bit_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [4:0]  ctrl_shiftamt,
  input  logic        ctrl_arith,
  input  logic        ctrl_start,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  amt_q, amt_d;
  logic        fill_q, fill_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic [31:0] stage;
  logic        take;
  logic        accept;

  // stage output for the current power of two
  always_comb begin
    stage = work_q;
    take  = 1'b0;
    unique case (cnt_q)
      3'd0: begin
        stage = {fill_q, work_q[31:1]};
        take  = amt_q[0];
      end
      3'd1: begin
        stage = {{2{fill_q}}, work_q[31:2]};
        take  = amt_q[1];
      end
      3'd2: begin
        stage = {{4{fill_q}}, work_q[31:4]};
        take  = amt_q[2];
      end
      3'd3: begin
        stage = {{8{fill_q}}, work_q[31:8]};
        take  = amt_q[3];
      end
      3'd4: begin
        stage = {{16{fill_q}}, work_q[31:16]};
        take  = amt_q[4];
      end
      default: begin
        stage = work_q;
        take  = 1'b0;
      end
    endcase
  end

  assign accept = ctrl_start &&
                  (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    amt_d   = amt_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      SHIFT: begin
        work_d = take ? stage : work_q;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          res_d   = take ? stage : work_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept) begin
      work_d  = data_operandA;
      amt_d   = ctrl_shiftamt;
      fill_d  = ctrl_arith & data_operandA[31];
      cnt_d   = 3'd0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign data_result    = res_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == SHIFT);

endmodule

// File: tb/tb_sr_32bit_seq.sv
// tb_sr_32bit_seq: directed and random checks of sr_32bit_seq
// against an arithmetic shift reference model.
module tb_sr_32bit_seq;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic        ctrl_arith;
  logic        ctrl_start;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int n_chk;
  int n_fail;
  logic [31:0] prev_res;

  sr_32bit_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .ctrl_arith     (ctrl_arith),
    .ctrl_start     (ctrl_start),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model(
    input logic [31:0] a,
    input logic [4:0]  s,
    input logic        ar
  );
    logic signed [31:0] sa;
    sa = a;
    if (ar) return sa >>> s;
    return a >> s;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a start now, checks 5 busy cycles, then the RDY cycle.
  // Leaves the bench 1 time unit into the RDY cycle.
  task automatic run_op(
    input logic [31:0] a,
    input logic [4:0]  s,
    input logic        ar,
    input logic [31:0] exp,
    input bit          pulse
  );
    data_operandA = a;
    ctrl_shiftamt = s;
    ctrl_arith    = ar;
    ctrl_start    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      ctrl_start = 1'b0;
      chk("busy", {31'd0, busy}, 32'd1);
      chk("rdy_low", {31'd0, data_resultRDY}, 32'd0);
      chk("res_hold", data_result, prev_res);
      if (pulse && k == 1) begin
        data_operandA = 32'hFFFF_FFFF;
        ctrl_shiftamt = 5'd0;
        ctrl_start    = 1'b1;
      end
    end
    @(posedge clock); #1;
    ctrl_start = 1'b0;
    chk("rdy", {31'd0, data_resultRDY}, 32'd1);
    chk("busy_low", {31'd0, busy}, 32'd0);
    chk("result", data_result, exp);
    prev_res = exp;
  endtask

  task automatic idle_chk;
    @(posedge clock); #1;
    chk("idle_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_res", data_result, prev_res);
  endtask

  initial begin
    logic [31:0] ra;
    logic [4:0]  rs;
    logic        rar;
    n_chk         = 0;
    n_fail        = 0;
    prev_res      = '0;
    reset_n       = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    ctrl_arith    = 1'b0;
    ctrl_start    = 1'b0;
    #1;
    chk("rst_res", data_result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 0);
    idle_chk();
    run_op(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 0);
    idle_chk();
    run_op(32'h7FFF_0000, 5'd16, 1'b1, 32'h0000_7FFF, 0);
    idle_chk();
    run_op(32'hF000_0000, 5'd5, 1'b1, 32'hFF80_0000, 0);
    idle_chk();
    run_op(32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 1);
    idle_chk();
    idle_chk();

    // back-to-back: second start held in the RDY cycle
    run_op(32'hC000_0000, 5'd4, 1'b1, 32'hFC00_0000, 0);
    run_op(32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 0);
    idle_chk();

    // reset in the middle of an operation
    data_operandA = 32'h8765_4321;
    ctrl_shiftamt = 5'd3;
    ctrl_arith    = 1'b1;
    ctrl_start    = 1'b1;
    @(posedge clock); #1;
    ctrl_start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("mid_rst_res", data_result, 32'd0);
    prev_res = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 7; k++) idle_chk();

    // start at the first edge after release
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    run_op(32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F, 0);
    idle_chk();

    // random operations, some back-to-back
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      rs  = 5'($urandom_range(0, 31));
      rar = 1'($urandom_range(0, 1));
      if (i % 4 == 0) ra[31] = 1'b1;
      run_op(ra, rs, rar, model(ra, rs, rar), 0);
      if ($urandom_range(0, 1) == 1) idle_chk();
    end
    idle_chk();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
